// File: rtl/poly_tobytes.sv
// NewHope polynomial serializer: reads N_COEFF 16-bit coefficients four at a time and packs them as 14-bit fields, 7 bytes per group.
// Optional freeze stage (x >= Q -> x - Q) enabled by defining POLY_TOBYTES_FREEZE_EN.

module poly_tobytes_freeze #(
    parameter int Q = 12289
) (
    input  logic [15:0] x,
    output logic [13:0] y
);
`ifdef POLY_TOBYTES_FREEZE_EN
    logic [15:0] red;

    always_comb begin
        red = (x >= 16'(Q)) ? x - 16'(Q) : x;
        y   = red[13:0];
    end

    logic unused_hi;
    assign unused_hi = ^red[15:14];
`else
    assign y = x[13:0];

    logic unused_hi;
    assign unused_hi = ^x[15:14];
`endif
endmodule

module poly_tobytes #(
    parameter int N_COEFF = 512,
    parameter int Q       = 12289
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [8:0]  ram_addr,
    input  logic [15:0] ram_dout,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready
);
    localparam int                GRP_W    = 7;
    localparam logic [GRP_W-1:0]  GRP_LAST = GRP_W'(N_COEFF / 4 - 1);
    localparam logic [2:0]        FETCH_LAST = 3'd4;
    localparam logic [2:0]        BYTE_LAST  = 3'd6;

    typedef enum logic [1:0] {IDLE, FETCH, EMIT, FINISH} state_t;

    state_t            state, state_nx;
    logic [GRP_W-1:0]  grp;
    logic [2:0]        fcnt;
    logic [2:0]        bidx;
    logic [3:0][13:0]  t;
    logic [55:0]       t_flat;
    logic [13:0]       frz;
    logic [1:0]        slot;
    logic              xfer;

    poly_tobytes_freeze #(.Q(Q)) u_freeze (
        .x (ram_dout),
        .y (frz)
    );

    // t0 occupies the low bits, so the 7 output bytes are simply consecutive byte lanes.
    assign t_flat = t;
    assign xfer   = byte_valid && byte_ready;
    // Capture lags the address by one cycle: fcnt 1..4 fills slots 0..3.
    assign slot   = 2'(fcnt[1:0] - 2'd1);

    always_comb begin
        state_nx   = state;
        busy       = 1'b0;
        done       = 1'b0;
        byte_valid = 1'b0;
        byte_out   = 8'h00;
        ram_addr   = 9'd0;
        case (state)
            IDLE: begin
                if (start) state_nx = FETCH;
            end
            FETCH: begin
                busy = 1'b1;
                if (fcnt != FETCH_LAST) ram_addr = {grp, fcnt[1:0]};
                else                    state_nx = EMIT;
            end
            EMIT: begin
                busy       = 1'b1;
                byte_valid = 1'b1;
                byte_out   = t_flat[{bidx, 3'b000} +: 8];
                if (xfer && bidx == BYTE_LAST)
                    state_nx = (grp == GRP_LAST) ? FINISH : FETCH;
            end
            FINISH: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            grp   <= '0;
            fcnt  <= '0;
            bidx  <= '0;
            t     <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        grp  <= '0;
                        fcnt <= '0;
                        bidx <= '0;
                    end
                end
                FETCH: begin
                    if (fcnt != 3'd0) t[slot] <= frz;
                    if (fcnt == FETCH_LAST) begin
                        fcnt <= '0;
                        bidx <= '0;
                    end else begin
                        fcnt <= fcnt + 3'd1;
                    end
                end
                EMIT: begin
                    if (xfer) begin
                        if (bidx == BYTE_LAST) begin
                            bidx <= '0;
                            if (grp != GRP_LAST) grp <= grp + 1'b1;
                        end else begin
                            bidx <= bidx + 3'd1;
                        end
                    end
                end
                FINISH: begin
                    grp <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_poly_tobytes.sv
// Directed bench for poly_tobytes: byte stream, handshake stalls, ignored start, mid-run reset.
module tb_poly_tobytes;
    localparam int N_COEFF = 512;
    localparam int Q       = 12289;
    localparam int NBYTES  = N_COEFF * 7 / 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, byte_valid;
    logic        byte_ready = 1'b1;
    logic [8:0]  ram_addr;
    logic [15:0] ram_dout = 16'h0;
    logic [7:0]  byte_out;

    logic [15:0] mem [0:N_COEFF-1];
    logic [7:0]  cap [0:1023];
    int          nbytes = 0;
    int          ndone  = 0;
    int          checks = 0;
    int          errors = 0;

    poly_tobytes #(.N_COEFF(N_COEFF), .Q(Q)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .ram_addr   (ram_addr),
        .ram_dout   (ram_dout),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_dout <= mem[ram_addr];

    // A transfer seen here happens on the following rising edge.
    always @(negedge clk) begin
        if (rst && byte_valid && byte_ready) begin
            if (nbytes < 1024) cap[nbytes] = byte_out;
            nbytes = nbytes + 1;
        end
        if (done) ndone = ndone + 1;
    end

    function automatic logic [13:0] coef(input int a);
        logic [15:0] x;
        x = mem[a];
`ifdef POLY_TOBYTES_FREEZE_EN
        if (x >= 16'(Q)) x = x - 16'(Q);
`endif
        return x[13:0];
    endfunction

    function automatic logic [7:0] model_byte(input int i);
        int g, k;
        logic [13:0] t0, t1, t2, t3;
        g = i / 7;
        k = i % 7;
        t0 = coef(4*g);   t1 = coef(4*g+1);
        t2 = coef(4*g+2); t3 = coef(4*g+3);
        case (k)
            0: return t0[7:0];
            1: return {t1[1:0], t0[13:8]};
            2: return t1[9:2];
            3: return {t2[3:0], t1[13:10]};
            4: return t2[11:4];
            5: return {t3[5:0], t2[13:12]};
            default: return t3[13:6];
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op();
        @(posedge clk); #1;
        nbytes = 0;
        ndone  = 0;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 4000; i++) begin
            if (ndone > 0) break;
            @(posedge clk); #1;
        end
        chk({tag, "_done_seen"}, 32'(ndone > 0), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_bytes(input int n);
        for (int i = 0; i < 4000; i++) begin
            if (nbytes >= n) break;
            @(posedge clk); #1;
        end
        chk("wait_bytes", 32'(nbytes >= n), 32'd1);
    endtask

    task automatic chk_stream(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < NBYTES; i++)
            if (cap[i] !== model_byte(i)) bad++;
        chk({tag, "_bytes_wrong"}, 32'(bad), 32'd0);
        chk({tag, "_count"}, 32'(nbytes), 32'(NBYTES));
        chk({tag, "_done_pulses"}, 32'(ndone), 32'd1);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < N_COEFF; i++) mem[i] = 16'((i * 1237 + 11) % (2 * Q));
    endtask

    task automatic fill_zero();
        for (int i = 0; i < N_COEFF; i++) mem[i] = 16'h0;
    endtask

    logic [7:0] exp7 [0:6];
    logic [7:0] b3;

    initial begin
        fill_zero();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(byte_valid), 32'd0);
        chk("rst_byte", 32'(byte_out), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Coefficients 0..3 in the first group.
        for (int i = 0; i < 4; i++) mem[i] = 16'(i);
        start_op();
        @(negedge clk);
        chk("fetch_busy", 32'(busy), 32'd1);
        chk("fetch_valid", 32'(byte_valid), 32'd0);
        chk("fetch_addr0", 32'(ram_addr), 32'd0);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("fetch_addr_seq", 32'(ram_addr), 32'(i));
        end
        wait_done("seq");
        exp7[0] = 8'h00; exp7[1] = 8'h40; exp7[2] = 8'h00; exp7[3] = 8'h20;
        exp7[4] = 8'h00; exp7[5] = 8'h0C; exp7[6] = 8'h00;
        for (int i = 0; i < 7; i++) chk("seq_first7", 32'(cap[i]), 32'(exp7[i]));
        chk_stream("seq");

        // All-zero RAM.
        fill_zero();
        start_op();
        wait_done("zero");
        chk_stream("zero");

        // Coefficient equal to Q exercises the freeze boundary.
        mem[0] = 16'(Q);
        start_op();
        wait_done("q");
`ifdef POLY_TOBYTES_FREEZE_EN
        chk("q_byte0", 32'(cap[0]), 32'h00);
        chk("q_byte1", 32'(cap[1]), 32'h00);
`else
        chk("q_byte0", 32'(cap[0]), 32'h01);
        chk("q_byte1", 32'(cap[1]), 32'h30);
`endif
        chk("q_count", 32'(nbytes), 32'(NBYTES));

        // Full pattern in [0, 2Q).
        fill_pattern();
        start_op();
        wait_done("pat");
        chk_stream("pat");

        // Stall on the 4th byte.
        start_op();
        wait_bytes(3);
        byte_ready = 1'b0;
        b3 = model_byte(3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_byte", 32'(byte_out), 32'(b3));
            chk("stall_valid", 32'(byte_valid), 32'd1);
        end
        chk("stall_addr", 32'(ram_addr), 32'd0);
        chk("stall_count", 32'(nbytes), 32'd3);
        @(posedge clk); #1;
        byte_ready = 1'b1;
        wait_done("stall");
        chk_stream("stall");

        // start during EMIT must be ignored.
        start_op();
        wait_bytes(10);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("restart");
        repeat (20) @(posedge clk);
        #1;
        chk_stream("restart");

        // Reset mid-stream after 100 transfers.
        start_op();
        wait_bytes(100);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_valid", 32'(byte_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(ndone), 32'd0);
        chk("abort_count", 32'(nbytes), 32'd100);
        start_op();
        wait_done("after_abort");
        chk_stream("after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
